// File: rtl/nx_ia_arb_pkg.sv
// nx_ia_arb_pkg: shared types and constants for the indirect access arbiter.
package nx_ia_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_HW, OWN_SW} owner_e;
    localparam int STARVE_CNT_W = 8;
endpackage

// File: rtl/nx_indirect_access_arb.sv
// nx_indirect_access_arb: single-port RAM arbiter between SW indirect access and the HW datapath.
// Optional SW starvation guard enabled by defining NX_IA_ARB_STARVE_GUARD_EN.
module nx_indirect_access_arb
    import nx_ia_arb_pkg::*;
#(
    parameter int N_ADDR_BITS  = 9,
    parameter int N_DATA_BITS  = 96,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_cs,
    input  logic                   sw_we,
    input  logic [N_ADDR_BITS-1:0] sw_add,
    input  logic [N_DATA_BITS-1:0] sw_wdat,
    input  logic                   yield,
    output logic                   grant,
    output logic [N_DATA_BITS-1:0] sw_rdat,
    input  logic                   hw_req,
    input  logic                   hw_we,
    input  logic [N_ADDR_BITS-1:0] hw_add,
    input  logic [N_DATA_BITS-1:0] hw_wdat,
    output logic                   hw_gnt,
    output logic                   hw_rvld,
    output logic [N_DATA_BITS-1:0] hw_rdat,
    output logic                   ram_cs,
    output logic                   ram_we,
    output logic [N_ADDR_BITS-1:0] ram_add,
    output logic [N_DATA_BITS-1:0] ram_wdat,
    input  logic [N_DATA_BITS-1:0] ram_rdat
);
    owner_e                 rd_owner_r;
    logic [N_DATA_BITS-1:0] sw_hold_r;
    logic                   starve_hit;
    logic                   force_sw;

`ifdef NX_IA_ARB_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt_r;

    assign starve_hit = int'(starve_cnt_r) >= STARVE_LIMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt_r <= '0;
        else if (grant || !sw_cs)
            starve_cnt_r <= '0;
        else if (hw_gnt && starve_cnt_r != '1)
            starve_cnt_r <= starve_cnt_r + 1'b1;
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Grants are gated by rst_n so the RAM stays idle while reset is held.
    assign force_sw = sw_cs && (yield || starve_hit);
    assign grant    = rst_n && (force_sw || (sw_cs && !hw_req));
    assign hw_gnt   = rst_n && hw_req && !force_sw;

    assign ram_cs   = grant || hw_gnt;
    assign ram_we   = grant ? sw_we : (hw_gnt && hw_we);
    assign ram_add  = grant ? sw_add : hw_add;
    assign ram_wdat = grant ? sw_wdat : hw_wdat;

    assign hw_rvld  = rd_owner_r == OWN_HW;
    assign hw_rdat  = ram_rdat;
    assign sw_rdat  = (rd_owner_r == OWN_SW) ? ram_rdat : sw_hold_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_r <= OWN_NONE;
            sw_hold_r  <= '0;
        end else begin
            rd_owner_r <= (grant && !sw_we) ? OWN_SW : (hw_gnt && !hw_we) ? OWN_HW : OWN_NONE;
            if (rd_owner_r == OWN_SW)
                sw_hold_r <= ram_rdat;
        end
    end
endmodule
